// File: rtl/alu_mc.sv
// Multi-cycle WIDTH-bit ALU (ADD/SUB/AND/OR/XOR/SLT 1 edge, MUL/MULHU WIDTH+1 edges incl. accept) with registered NZCV.
// Valid/ready on both sides; a stalled consumer holds DONE and drops in_ready, back-pressuring issue.
module alu_mc #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       control,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [WIDTH-1:0]   r_result;
  logic [3:0]         r_flags;
  logic [2*WIDTH-1:0] r_acc;
  logic [2*WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [CW-1:0]      r_cnt;
  logic               r_hi;

  logic               w_idle;
  logic               w_in_ready;
  logic               w_accept;
  logic               w_is_mul;
  logic               w_mul_last;
  logic [WIDTH:0]     w_add;
  logic [WIDTH:0]     w_sub;
  logic               w_add_v;
  logic               w_sub_v;
  logic [WIDTH-1:0]   w_alu_res;
  logic               w_alu_c;
  logic               w_alu_v;
  logic [2*WIDTH-1:0] w_acc_next;
  logic [WIDTH-1:0]   w_mul_res;

  // Any encoding other than MUL/DONE behaves as IDLE.
  always_comb begin
    w_idle     = (r_state != S_MUL) && (r_state != S_DONE);
    w_in_ready = w_idle || ((r_state == S_DONE) && out_ready);
    w_accept   = in_valid && w_in_ready;
    w_is_mul   = (control[2:1] == 2'b11);
    w_mul_last = (r_state == S_MUL) && (r_cnt == '0);
  end

  always_comb begin
    w_next = S_IDLE;
    case (r_state)
      S_MUL: w_next = w_mul_last ? S_DONE : S_MUL;
      S_DONE: begin
        if (w_accept)       w_next = w_is_mul ? S_MUL : S_DONE;
        else if (out_ready) w_next = S_IDLE;
        else                w_next = S_DONE;
      end
      default: begin
        if (w_accept) w_next = w_is_mul ? S_MUL : S_DONE;
      end
    endcase
  end

  always_comb begin
    w_add     = {1'b0, a} + {1'b0, b};
    w_sub     = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
    w_add_v   = (a[WIDTH-1] == b[WIDTH-1]) && (w_add[WIDTH-1] != a[WIDTH-1]);
    w_sub_v   = (a[WIDTH-1] != b[WIDTH-1]) && (w_sub[WIDTH-1] != a[WIDTH-1]);
    w_alu_res = '0;
    w_alu_c   = 1'b0;
    w_alu_v   = 1'b0;
    case (control)
      3'b000: begin w_alu_res = w_add[WIDTH-1:0]; w_alu_c = w_add[WIDTH]; w_alu_v = w_add_v; end
      3'b001: begin w_alu_res = w_sub[WIDTH-1:0]; w_alu_c = w_sub[WIDTH]; w_alu_v = w_sub_v; end
      3'b010: w_alu_res = a & b;
      3'b011: w_alu_res = a | b;
      3'b100: w_alu_res = a ^ b;
      3'b101: w_alu_res = {{(WIDTH-1){1'b0}}, w_sub[WIDTH-1] ^ w_sub_v};
      default: w_alu_res = '0;
    endcase
  end

  // Shift-add: the multiplicand walks left while the multiplier walks right.
  always_comb begin
    w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);
    w_mul_res  = r_hi ? w_acc_next[2*WIDTH-1:WIDTH] : w_acc_next[WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_result <= '0;
      r_flags  <= '0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
      r_hi     <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        if (w_is_mul) begin
          r_mcand  <= {{WIDTH{1'b0}}, a};
          r_mplier <= b;
          r_acc    <= '0;
          r_cnt    <= CW'(WIDTH - 1);
          r_hi     <= control[0];
        end else begin
          r_result <= w_alu_res;
          r_flags  <= {w_alu_res[WIDTH-1], (w_alu_res == '0), w_alu_c, w_alu_v};
        end
      end else if (r_state == S_MUL) begin
        r_acc    <= w_acc_next;
        r_mcand  <= r_mcand << 1;
        r_mplier <= r_mplier >> 1;
        r_cnt    <= r_cnt - CW'(1);
        if (w_mul_last) begin
          r_result <= w_mul_res;
          r_flags  <= {w_mul_res[WIDTH-1], (w_mul_res == '0), 2'b00};
        end
      end
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = (r_state == S_DONE);
  assign result    = r_result;
  assign flags     = r_flags;

endmodule

// File: tb/tb_alu_mc.sv
// Directed bench for alu_mc: a 32-bit and an 8-bit instance sharing clock and reset.
module tb_alu_mc;

  logic        clk;
  logic        rst;

  logic        v32, ir32, ov32, ordy32;
  logic [31:0] a32, b32, res32;
  logic [2:0]  c32;
  logic [3:0]  fl32;

  logic        v8, ir8, ov8, ordy8;
  logic [7:0]  a8, b8, res8;
  logic [2:0]  c8;
  logic [3:0]  fl8;

  int n_cmp;
  int n_fail;

  alu_mc #(.WIDTH(32)) u_alu32 (
    .clk(clk), .rst(rst), .in_valid(v32), .in_ready(ir32), .a(a32), .b(b32),
    .control(c32), .out_valid(ov32), .out_ready(ordy32), .result(res32), .flags(fl32)
  );

  alu_mc #(.WIDTH(8)) u_alu8 (
    .clk(clk), .rst(rst), .in_valid(v8), .in_ready(ir8), .a(a8), .b(b8),
    .control(c8), .out_valid(ov8), .out_ready(ordy8), .result(res8), .flags(fl8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive32(input logic [2:0] ctl, input logic [31:0] opa, input logic [31:0] opb);
    c32 = ctl; a32 = opa; b32 = opb; v32 = 1'b1; ordy32 = 1'b1;
    @(posedge clk); #1;
    v32 = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_cmp++; if (ov32 !== 1'b0) begin n_fail++; $display("FAIL reset_ov32: got %b want 0", ov32); end
    n_cmp++; if (res32 !== 32'h0) begin n_fail++; $display("FAIL reset_res32: got %h want 0", res32); end
    n_cmp++; if (fl32 !== 4'h0) begin n_fail++; $display("FAIL reset_fl32: got %b want 0000", fl32); end
    n_cmp++; if (ir32 !== 1'b1) begin n_fail++; $display("FAIL reset_ir32: got %b want 1", ir32); end
    n_cmp++; if (ov8 !== 1'b0 || ir8 !== 1'b1) begin n_fail++; $display("FAIL reset_8: got ov=%b ir=%b want ov=0 ir=1", ov8, ir8); end
  endtask

  task automatic test_add;
    drive32(3'b000, 32'h7FFF_FFFF, 32'h1);
    n_cmp++; if (ov32 !== 1'b1) begin n_fail++; $display("FAIL add_ov: got %b want 1", ov32); end
    n_cmp++; if (res32 !== 32'h8000_0000) begin n_fail++; $display("FAIL add_res: got %h want 80000000", res32); end
    n_cmp++; if (fl32 !== 4'b1001) begin n_fail++; $display("FAIL add_flags: got %b want 1001", fl32); end
    drive32(3'b000, 32'hFFFF_FFFF, 32'h1);
    n_cmp++; if (res32 !== 32'h0 || fl32 !== 4'b0110) begin n_fail++; $display("FAIL add_carry: got %h/%b want 0/0110", res32, fl32); end
  endtask

  task automatic test_sub;
    drive32(3'b001, 32'd5, 32'd5);
    n_cmp++; if (res32 !== 32'h0 || fl32 !== 4'b0110) begin n_fail++; $display("FAIL sub_eq: got %h/%b want 0/0110", res32, fl32); end
    drive32(3'b001, 32'd3, 32'd5);
    n_cmp++; if (ov32 !== 1'b1) begin n_fail++; $display("FAIL sub_b2b_ov: got %b want 1", ov32); end
    n_cmp++; if (res32 !== 32'hFFFF_FFFE || fl32 !== 4'b1000) begin n_fail++; $display("FAIL sub_borrow: got %h/%b want fffffffe/1000", res32, fl32); end
  endtask

  task automatic test_logic;
    drive32(3'b101, 32'hFFFF_FFFF, 32'h1);
    n_cmp++; if (res32 !== 32'h1 || fl32 !== 4'b0000) begin n_fail++; $display("FAIL slt: got %h/%b want 1/0000", res32, fl32); end
    drive32(3'b100, 32'hF0F0_F0F0, 32'hFFFF_0000);
    n_cmp++; if (res32 !== 32'h0F0F_F0F0 || fl32 !== 4'b0000) begin n_fail++; $display("FAIL xor: got %h/%b want 0f0ff0f0/0000", res32, fl32); end
    drive32(3'b011, 32'h8000_0000, 32'h1);
    n_cmp++; if (res32 !== 32'h8000_0001 || fl32 !== 4'b1000) begin n_fail++; $display("FAIL or: got %h/%b want 80000001/1000", res32, fl32); end
    @(posedge clk); #1;
    n_cmp++; if (ov32 !== 1'b0) begin n_fail++; $display("FAIL drain_idle: got ov=%b want 0", ov32); end
  endtask

  task automatic test_mul;
    c8 = 3'b110; a8 = 8'hFF; b8 = 8'hFF; v8 = 1'b1; ordy8 = 1'b1;
    for (int e = 1; e <= 9; e++) begin
      @(posedge clk); #1;
      v8 = 1'b0;
      if (e < 9) begin
        n_cmp++; if (ov8 !== 1'b0 || ir8 !== 1'b0) begin n_fail++; $display("FAIL mul_busy e=%0d: got ov=%b ir=%b want 0/0", e, ov8, ir8); end
      end
    end
    n_cmp++; if (ov8 !== 1'b1) begin n_fail++; $display("FAIL mul_ov: got %b want 1", ov8); end
    n_cmp++; if (res8 !== 8'h01 || fl8 !== 4'b0000) begin n_fail++; $display("FAIL mul_res: got %h/%b want 01/0000", res8, fl8); end
    c8 = 3'b111; v8 = 1'b1;
    for (int e = 1; e <= 9; e++) begin
      @(posedge clk); #1;
      v8 = 1'b0;
    end
    n_cmp++; if (ov8 !== 1'b1) begin n_fail++; $display("FAIL mulhu_ov: got %b want 1", ov8); end
    n_cmp++; if (res8 !== 8'hFE || fl8 !== 4'b1000) begin n_fail++; $display("FAIL mulhu_res: got %h/%b want fe/1000", res8, fl8); end
  endtask

  task automatic test_back_to_back;
    c32 = 3'b000; a32 = 32'd1; b32 = 32'd2; v32 = 1'b1; ordy32 = 1'b0;
    @(posedge clk); #1;
    v32 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      n_cmp++; if (ov32 !== 1'b1 || res32 !== 32'd3 || ir32 !== 1'b0) begin
        n_fail++; $display("FAIL stall_hold i=%0d: got ov=%b res=%h ir=%b want 1/3/0", i, ov32, res32, ir32);
      end
      @(posedge clk); #1;
    end
    c32 = 3'b010; a32 = 32'hC; b32 = 32'hA; v32 = 1'b1; ordy32 = 1'b1;
    #1;
    n_cmp++; if (ir32 !== 1'b1) begin n_fail++; $display("FAIL release_ir: got %b want 1", ir32); end
    @(posedge clk); #1;
    v32 = 1'b0;
    n_cmp++; if (ov32 !== 1'b1 || res32 !== 32'h8 || fl32 !== 4'b0000) begin
      n_fail++; $display("FAIL b2b_and: got ov=%b res=%h fl=%b want 1/8/0000", ov32, res32, fl32);
    end
  endtask

  task automatic test_reset_mid_mul;
    c8 = 3'b110; a8 = 8'd3; b8 = 8'd5; v8 = 1'b1; ordy8 = 1'b1;
    @(posedge clk); #1;
    v8 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
    end
    n_cmp++; if (ov8 !== 1'b0) begin n_fail++; $display("FAIL mid_mul_ov: got %b want 0", ov8); end
    rst = 1'b1; c8 = 3'b000; a8 = 8'd9; b8 = 8'd9; v8 = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; v8 = 1'b0;
    n_cmp++; if (ov8 !== 1'b0 || res8 !== 8'h0 || fl8 !== 4'h0 || ir8 !== 1'b1) begin
      n_fail++; $display("FAIL mid_mul_reset: got ov=%b res=%h fl=%b ir=%b want 0/00/0000/1", ov8, res8, fl8, ir8);
    end
    c8 = 3'b000; a8 = 8'd2; b8 = 8'd2; v8 = 1'b1;
    @(posedge clk); #1;
    v8 = 1'b0;
    n_cmp++; if (ov8 !== 1'b1 || res8 !== 8'd4 || fl8 !== 4'b0000) begin
      n_fail++; $display("FAIL post_reset_add: got ov=%b res=%h fl=%b want 1/04/0000", ov8, res8, fl8);
    end
  endtask

  initial begin
    n_cmp = 0; n_fail = 0;
    rst = 1'b1;
    v32 = 1'b0; ordy32 = 1'b0; a32 = '0; b32 = '0; c32 = '0;
    v8 = 1'b0; ordy8 = 1'b0; a8 = '0; b8 = '0; c8 = '0;
    test_reset;
    test_add;
    test_sub;
    test_logic;
    test_mul;
    test_back_to_back;
    test_reset_mid_mul;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
